// File: rtl/timer_tick_gen.sv
// Programmable tick prescaler: one-cycle tick enable every div_act clocks,
// with start/stop, periodic or one-shot mode and a shadowed divisor reload.
//
// state | meaning
// IDLE  | stopped, counter held at 0
// RUN   | counting 0 .. div_act-1, tick on wrap
// DONE  | one-shot expired, counter held at 0 until start or stop
module timer_tick_gen #(
    parameter int unsigned W           = 26,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] div_in_i,
    input  logic         load_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         oneshot_i,
    output logic         tick_o,
    output logic         running_o,
    output logic         done_o,
    output logic         load_err_o,
    output logic [W-1:0] cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] MIN_DIV = W'(2);
    localparam logic [W-1:0] RST_DIV = W'(DEFAULT_DIV);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_shadow_q, div_shadow_d;
    logic [W-1:0] div_act_q, div_act_d;
    logic         mode_q, mode_d;
    logic         tick_q, tick_d;
    logic         load_err_q, load_err_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_shadow_q <= RST_DIV;
            div_act_q    <= RST_DIV;
            mode_q       <= 1'b0;
            tick_q       <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_shadow_q <= div_shadow_d;
            div_act_q    <= div_act_d;
            mode_q       <= mode_d;
            tick_q       <= tick_d;
            load_err_q   <= load_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_shadow_d = div_shadow_q;
        div_act_d    = div_act_q;
        mode_d       = mode_q;
        tick_d       = 1'b0;
        load_err_d   = 1'b0;

        // Start and wrap read the old shadow, so a coincident load lands one period later.
        if (load_i) begin
            if (div_in_i >= MIN_DIV) begin
                div_shadow_d = div_in_i;
            end else begin
                load_err_d = 1'b1;
            end
        end

        if (stop_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start_i) begin
            state_d   = RUN;
            cnt_d     = '0;
            div_act_d = div_shadow_q;
            mode_d    = oneshot_i;
        end else begin
            case (state_q)
                RUN: begin
                    if (cnt_q == div_act_q - ONE) begin
                        cnt_d     = '0;
                        tick_d    = 1'b1;
                        div_act_d = div_shadow_q;
                        state_d   = mode_q ? DONE : RUN;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    assign tick_o     = tick_q;
    assign running_o  = (state_q == RUN);
    assign done_o     = (state_q == DONE);
    assign load_err_o = load_err_q;
    assign cnt_o      = cnt_q;

endmodule

// File: tb/tb_timer_tick_gen.sv
// Directed bench for timer_tick_gen (W=8, DEFAULT_DIV=8): periodic, one-shot,
// shadow reload, rejected loads, stop/start priority and async reset.
module tb_timer_tick_gen;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] div_in;
    logic         load;
    logic         start;
    logic         stop;
    logic         oneshot;
    logic         tick;
    logic         running;
    logic         done;
    logic         load_err;
    logic [W-1:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;

    timer_tick_gen #(.W(W), .DEFAULT_DIV(8)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .div_in_i   (div_in),
        .load_i     (load),
        .start_i    (start),
        .stop_i     (stop),
        .oneshot_i  (oneshot),
        .tick_o     (tick),
        .running_o  (running),
        .done_o     (done),
        .load_err_o (load_err),
        .cnt_o      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_tick, input logic e_run,
                           input logic e_done, input int e_cnt);
        chk({tag, ".tick"}, {31'd0, tick}, {31'd0, e_tick});
        chk({tag, ".running"}, {31'd0, running}, {31'd0, e_run});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
        chk({tag, ".cnt"}, {24'd0, cnt}, e_cnt);
    endtask

    task automatic do_load(input int d);
        div_in = W'(d);
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic do_start(input logic os);
        oneshot = os;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        div_in  = '0;
        load    = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        oneshot = 1'b0;
        #3;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 0);
        chk("reset.load_err", {31'd0, load_err}, 0);
        step();
        rst_n = 1'b1;
        step();
        chk_all("idle", 1'b0, 1'b0, 1'b0, 0);

        // 1: periodic div=4
        do_load(4);
        do_start(1'b0);
        chk_all("t1.e0", 1'b0, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_all($sformatf("t1.e%0d", k), (k % 4) == 0, 1'b1, 1'b0, k % 4);
        end
        do_stop();
        chk_all("t1.stop", 1'b0, 1'b0, 1'b0, 0);

        // 2: one-shot div=5
        do_load(5);
        do_start(1'b1);
        chk_all("t2.e0", 1'b0, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_all($sformatf("t2.e%0d", k), 1'b0, 1'b1, 1'b0, k);
        end
        step();
        chk_all("t2.e5", 1'b1, 1'b0, 1'b1, 0);
        for (int k = 6; k <= 25; k++) begin
            step();
            chk_all($sformatf("t2.e%0d", k), 1'b0, 1'b0, 1'b1, 0);
        end
        do_stop();
        chk_all("t2.stop", 1'b0, 1'b0, 1'b0, 0);

        // 3: reload at cnt=1 takes effect at next wrap; load coincident with wrap lags one period
        do_load(4);
        do_start(1'b0);
        step();
        chk_all("t3.e1", 1'b0, 1'b1, 1'b0, 1);
        div_in = 8'd6;
        load   = 1'b1;
        step();
        load   = 1'b0;
        chk_all("t3.e2", 1'b0, 1'b1, 1'b0, 2);
        step();
        chk_all("t3.e3", 1'b0, 1'b1, 1'b0, 3);
        step();
        chk_all("t3.e4", 1'b1, 1'b1, 1'b0, 0);
        for (int k = 5; k <= 21; k++) begin
            step();
            chk_all($sformatf("t3.e%0d", k), ((k - 4) % 6) == 0, 1'b1, 1'b0, (k - 4) % 6);
        end
        div_in = 8'd3;
        load   = 1'b1;
        step();
        load   = 1'b0;
        chk_all("t3.e22", 1'b1, 1'b1, 1'b0, 0);
        for (int k = 23; k <= 28; k++) begin
            step();
            chk_all($sformatf("t3.e%0d", k), ((k - 22) % 6) == 0, 1'b1, 1'b0, (k - 22) % 6);
        end
        for (int k = 29; k <= 31; k++) begin
            step();
            chk_all($sformatf("t3.e%0d", k), ((k - 28) % 3) == 0, 1'b1, 1'b0, (k - 28) % 3);
        end
        do_stop();

        // 4: rejected loads
        do_load(4);
        do_start(1'b0);
        div_in = 8'd1;
        load   = 1'b1;
        step();
        load   = 1'b0;
        chk("t4.err1", {31'd0, load_err}, 1);
        chk("t4.cnt1", {24'd0, cnt}, 1);
        step();
        chk("t4.err1_clr", {31'd0, load_err}, 0);
        div_in = 8'd0;
        load   = 1'b1;
        step();
        load   = 1'b0;
        chk("t4.err0", {31'd0, load_err}, 1);
        step();
        chk("t4.err0_clr", {31'd0, load_err}, 0);
        chk_all("t4.e4", 1'b1, 1'b1, 1'b0, 0);
        for (int k = 5; k <= 8; k++) begin
            step();
            chk_all($sformatf("t4.e%0d", k), (k % 4) == 0, 1'b1, 1'b0, k % 4);
        end

        // 5: stop at terminal count suppresses tick; stop beats start
        for (int k = 9; k <= 11; k++) begin
            step();
            chk_all($sformatf("t5.e%0d", k), 1'b0, 1'b1, 1'b0, k % 4);
        end
        do_stop();
        chk_all("t5.stop_tc", 1'b0, 1'b0, 1'b0, 0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk_all("t5.both_idle", 1'b0, 1'b0, 1'b0, 0);
        do_start(1'b0);
        chk_all("t5.restart", 1'b0, 1'b1, 1'b0, 0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk_all("t5.both_run", 1'b0, 1'b0, 1'b0, 0);

        // 6: async reset mid-period restores default divisor of 8
        do_load(4);
        do_start(1'b0);
        step();
        step();
        chk_all("t6.pre", 1'b0, 1'b1, 1'b0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t6.rst", 1'b0, 1'b0, 1'b0, 0);
        chk("t6.rst.load_err", {31'd0, load_err}, 0);
        step();
        rst_n = 1'b1;
        do_start(1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_all($sformatf("t6.e%0d", k), k == 8, 1'b1, 1'b0, k % 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
